mips_debug_probe: RTL and testbench

- Host-side counterpart of the core's debug port. It drives debug_en, debug_step and debug_addr, and reads back debug_data.
- Single-steps a halted core on request.
- On a dump request, sweeps the debug address space, captures each word and streams the words out as a framed byte stream on a valid/ready interface.
- Sits between the mips_core debug port and a byte sink such as a UART transmitter.

---
 rtl/mips_debug_probe_pkg.sv | 24 ++
 rtl/mips_debug_probe_dbg_byte_ser.sv | 41 ++++
 rtl/mips_debug_probe.sv | 121 ++++++++++++
 tb/tb_mips_debug_probe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_probe_pkg.sv
// Shared definitions for the mips_debug_probe host-side debug controller.
package mips_debug_probe_pkg;

  localparam int DBG_ADDR_W = 7;
  localparam int DBG_DATA_W = 32;
  localparam logic [7:0] DBG_HDR = 8'hA5;

  // state   | meaning
  // IDLE    | waiting for step_req / dump_req
  // STEP    | debug_step held high for STEP_W cycles
  // HDR     | frame header byte offered on the stream
  // SETADDR | debug_addr just updated, core mux settling
  // WAIT    | read latency countdown, word captured on the last cycle
  // SEND    | captured word streamed out MSB first
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_HDR,
    ST_SETADDR,
    ST_WAIT,
    ST_SEND
  } dbg_state_t;

endpackage

// File: rtl/mips_debug_probe_dbg_byte_ser.sv
// Word-to-byte serializer: loads one word, emits its bytes MSB first on valid/ready.
module dbg_byte_ser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [7:0]        data,
  output logic              valid,
  output logic              done
);

  localparam int NB  = DATA_W / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] sreg;
  logic [BCW-1:0]    byte_cnt;

  assign data = sreg[DATA_W-1 -: 8];
  assign done = valid && ready && (byte_cnt == BCW'(NB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      sreg     <= word;
      byte_cnt <= '0;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      // shifting leaves the register empty once the word is fully sent
      sreg     <= sreg << 8;
      byte_cnt <= byte_cnt + BCW'(1);
      if (byte_cnt == BCW'(NB - 1)) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_debug_probe.sv
// Host-side debug probe: single-steps a halted core and dumps its debug
// address space as a framed byte stream (header 0xA5, then 4 bytes per word).
module mips_debug_probe
  import mips_debug_probe_pkg::*;
#(
  parameter int ADDR_W   = DBG_ADDR_W,
  parameter int DATA_W   = DBG_DATA_W,
  parameter int ADDR_MAX = 63,
  parameter int READ_LAT = 1,
  parameter int STEP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              step_req,
  input  logic              dump_req,
  output logic              busy,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int SCW = $clog2(STEP_W) + 1;
  localparam int WCW = $clog2(READ_LAT) + 1;

  dbg_state_t        state, state_nxt;
  logic [SCW-1:0]    step_cnt, step_cnt_nxt;
  logic [WCW-1:0]    wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              ser_load, ser_done, ser_valid;
  logic [7:0]        ser_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      step_cnt   <= '0;
      wait_cnt   <= '0;
      debug_addr <= '0;
      debug_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_cnt   <= step_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      debug_addr <= addr_nxt;
      debug_en   <= halt;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    wait_cnt_nxt = wait_cnt;
    addr_nxt     = debug_addr;
    ser_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        // step wins over a simultaneous dump; the dump is dropped
        if (step_req && debug_en) begin
          state_nxt    = ST_STEP;
          step_cnt_nxt = SCW'(STEP_W - 1);
        end else if (dump_req) begin
          state_nxt = ST_HDR;
        end
      end
      ST_STEP: begin
        if (step_cnt == '0) state_nxt = ST_IDLE;
        else step_cnt_nxt = step_cnt - SCW'(1);
      end
      ST_HDR: begin
        if (tx_ready) begin
          addr_nxt  = '0;
          state_nxt = ST_SETADDR;
        end
      end
      ST_SETADDR: begin
        wait_cnt_nxt = WCW'(READ_LAT - 1);
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          ser_load  = 1'b1;
          state_nxt = ST_SEND;
        end else begin
          wait_cnt_nxt = wait_cnt - WCW'(1);
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          if (debug_addr == ADDR_W'(ADDR_MAX)) begin
            state_nxt = ST_IDLE;
          end else begin
            addr_nxt  = debug_addr + ADDR_W'(1);
            state_nxt = ST_SETADDR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  dbg_byte_ser #(.DATA_W(DATA_W)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .word  (debug_data),
    .ready (tx_ready),
    .data  (ser_data),
    .valid (ser_valid),
    .done  (ser_done)
  );

  assign busy       = (state != ST_IDLE);
  assign debug_step = (state == ST_STEP);
  assign tx_valid   = (state == ST_HDR) || ser_valid;
  assign tx_data    = (state == ST_HDR) ? DBG_HDR : ser_data;

endmodule

// File: tb/tb_mips_debug_probe.sv
// Directed/randomized bench for mips_debug_probe; two instances (READ_LAT 1 and 2)
// share stimulus, each fed by a core model with the matching read latency.
module tb_mips_debug_probe;

  logic        clk, rst, halt, step_req, dump_req, tx_ready;
  logic        busy1, en1, step1, valid1, busy2, en2, step2, valid2;
  logic [6:0]  addr1, addr2;
  logic [31:0] data1, data2, pipe2, core_base;
  logic [7:0]  txd1, txd2;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q1[$], q2[$], exp_q[$];
  bit   st1, st2;
  logic [7:0] sd1, sd2;

  mips_debug_probe #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .halt(halt), .step_req(step_req), .dump_req(dump_req),
    .busy(busy1), .debug_en(en1), .debug_step(step1), .debug_addr(addr1),
    .debug_data(data1), .tx_data(txd1), .tx_valid(valid1), .tx_ready(tx_ready));

  mips_debug_probe #(.READ_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .halt(halt), .step_req(step_req), .dump_req(dump_req),
    .busy(busy2), .debug_en(en2), .debug_step(step2), .debug_addr(addr2),
    .debug_data(data2), .tx_data(txd2), .tx_valid(valid2), .tx_ready(tx_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core models: registered debug mux, one and two cycles deep
  always @(posedge clk) begin
    data1 <= core_base + 32'(addr1);
    pipe2 <= core_base + 32'(addr2);
    data2 <= pipe2;
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      st1 = 1'b0;
      st2 = 1'b0;
    end else begin
      if (st1) chk("stall_hold1", {31'd0, valid1, txd1}, {31'd0, 1'b1, sd1});
      if (st2) chk("stall_hold2", {31'd0, valid2, txd2}, {31'd0, 1'b1, sd2});
      st1 = valid1 && !tx_ready;  sd1 = txd1;
      st2 = valid2 && !tx_ready;  sd2 = txd2;
      if (valid1 && tx_ready) q1.push_back(txd1);
      if (valid2 && tx_ready) q2.push_back(txd2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [31:0] base);
    logic [31:0] w;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int a = 0; a <= 63; a++) begin
      w = base + 32'(a);
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] q[$]);
    chk({tag, "_len"}, 40'(q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
      chk({tag, "_byte"}, {8'd0, 16'(i), q[i]}, {8'd0, 16'(i), exp_q[i]});
      if (q[i] !== exp_q[i]) break;
    end
  endtask

  task automatic run_dump(input bit bp, input bit extra_dump, input logic [31:0] base);
    int n;
    core_base = base;
    build_exp(base);
    q1 = {};
    q2 = {};
    tx_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while ((busy1 || busy2) && n < 8000) begin
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_req = extra_dump && (q1.size() == 20 || q2.size() == 20);
      tick();
      n++;
    end
    dump_req = 1'b0;
    tx_ready = 1'b1;
    chk("dump_timeout", 40'(n < 8000), 40'd1);
    chk("addr_end1", 40'(addr1), 40'd63);
    chk("addr_end2", 40'(addr2), 40'd63);
    repeat (10) tick();
    chk("idle_after1", {38'd0, busy1, valid1}, 40'd0);
    cmp_frame("frame1", q1);
    cmp_frame("frame2", q2);
  endtask

  initial begin
    int n;
    rst = 1'b0; halt = 1'b0; step_req = 1'b0; dump_req = 1'b0; tx_ready = 1'b1;
    core_base = 32'h1000_0000;
    #1;
    chk("rst_outs1", {8'd0, busy1, en1, step1, valid1, 1'b0, addr1, txd1, 8'd0},
        {40'd0});
    chk("rst_outs2", {8'd0, busy2, en2, step2, valid2, 1'b0, addr2, txd2, 8'd0},
        {40'd0});
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // debug_en follows halt one cycle late
    halt = 1'b1;
    #1 chk("en_lag0", 40'(en1), 40'd0);
    tick();
    chk("en_lag1", 40'(en1), 40'd1);
    tick();

    // single step: pulse width and busy window
    step_req = 1'b1;
    chk("step_pre", 40'(step1), 40'd0);
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) halt = 1'b0;
      chk("step_hi", {38'd0, step1, busy1}, 40'd3);
      tick();
    end
    chk("step_lo", {38'd0, step1, busy1}, 40'd0);

    // step with debug mode off is ignored
    repeat (2) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("step_noen", {38'd0, step1, busy1}, 40'd0);
      tick();
    end

    // step and dump together: only the step happens
    halt = 1'b1;
    q1 = {};
    repeat (2) tick();
    step_req = 1'b1;
    dump_req = 1'b1;
    tick();
    step_req = 1'b0;
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("coll_step", {38'd0, step1, valid1}, 40'd2);
      tick();
    end
    repeat (4) begin
      chk("coll_idle", {38'd0, busy1, valid1}, 40'd0);
      tick();
    end
    chk("coll_nobytes", 40'(q1.size()), 40'd0);
    halt = 1'b0;

    // full dumps: free-flowing, then random backpressure
    run_dump(1'b0, 1'b0, 32'h1000_0000);
    run_dump(1'b1, 1'b0, $urandom);

    // reset while the 10th byte is on offer
    core_base = 32'h1000_0000;
    q1 = {};
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while (q1.size() < 10 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_mid_reach", 40'(q1.size()), 40'd10);
    rst = 1'b0;
    #1;
    chk("rst_mid1", {13'd0, valid1, addr1, busy1, txd1, 10'd0}, 40'd0);
    chk("rst_mid2", {13'd0, valid2, addr2, busy2, txd2, 10'd0}, 40'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // fresh frame after abort, with a dump_req mid-frame that must be dropped
    run_dump(1'b1, 1'b1, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
